// File: rtl/decoder_pkg.sv
// Shared definitions for the sweeping one-hot decoder.
// Build option: DECODER_SKIP_ZERO_EN keeps output bit 0 (hard-wired register 0)
// permanently low. With it, sweeps start at index 1.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Widest select the shared helper supports; decoders narrower than this truncate.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

`ifdef DECODER_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  // Index of the first output that a sweep visits.
  localparam int FIRST_IDX = SKIP_ZERO ? 1 : 0;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                                  input logic                 en);
    logic [MAX_OUT_W-1:0] r;
    r = '0;
    if (en) r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational SEL_W:2^SEL_W one-hot decoder with enable (all-zero when disabled).
module decoder_onehot
  import decoder_pkg::*;
#(
  parameter int SEL_W = 5
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  en_i,
  output logic [(1<<SEL_W)-1:0] onehot_o
);

  localparam int OUT_W = 1 << SEL_W;

  // The helper decodes at its widest size; only the low OUT_W bits can ever be set.
  assign onehot_o = OUT_W'(onehot(MAX_SEL_W'(sel_i), en_i));

endmodule

// File: rtl/decoder_sweep.sv
// Registered one-hot decoder with enable plus a self-timed sweep mode that walks
// a single one-hot bit across every output (register-file clear / BIST).
// Build option: DECODER_SKIP_ZERO_EN suppresses output bit 0 for direct decodes and sweeps.
module decoder_sweep
  import decoder_pkg::*;
#(
  parameter int SEL_W       = 5,
  parameter int STEP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [SEL_W-1:0]      i,
  input  logic                  sweep_start,
  input  logic                  sweep_abort,
  output logic [(1<<SEL_W)-1:0] d,
  output logic                  busy,
  output logic                  done,
  output logic [SEL_W-1:0]      idx
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [SEL_W-1:0] FIRST     = SEL_W'(FIRST_IDX);
  localparam logic [SEL_W-1:0] LAST      = SEL_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   d_q;

  logic [SEL_W-1:0]   dec_sel;
  logic               dec_en;
  logic [OUT_W-1:0]   dec_out;

  decoder_onehot #(
    .SEL_W (SEL_W)
  ) u_onehot (
    .sel_i    (dec_sel),
    .en_i     (dec_en),
    .onehot_o (dec_out)
  );

  // Next-state, counters and decoder select; the decoder output is next d.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dec_sel = i;
    dec_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sweep_start) begin
          state_d = ST_SWEEP;
          idx_d   = FIRST;
          cnt_d   = '0;
          dec_sel = FIRST;
          dec_en  = 1'b1;
        end else begin
          dec_sel = i;
          dec_en  = en && !(SKIP_ZERO && (i == '0));
        end
      end
      ST_SWEEP: begin
        if (sweep_abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            dec_sel = idx_q + 1'b1;
            dec_en  = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          dec_sel = idx_q;
          dec_en  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
      default: begin
        // Unused encoding 2'd3: fall back to IDLE with everything cleared.
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and decode output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      d_q     <= dec_out;
    end
  end

  assign d    = d_q;
  assign idx  = idx_q;
  assign busy = (state_q == ST_SWEEP);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_decoder_sweep.sv
// Directed self-checking bench for decoder_sweep: direct decode, full sweeps with
// hold 1 and hold 3, start/enable priority, abort and mid-sweep reset.
module tb_decoder_sweep;

`ifdef DECODER_SKIP_ZERO_EN
  localparam int FIRST_TB = 1;
`else
  localparam int FIRST_TB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [4:0]  i   = '0;
  logic        start1 = 1'b0, abort1 = 1'b0;
  logic        start3 = 1'b0, abort3 = 1'b0;

  logic [31:0] d1, d3;
  logic        busy1, busy3, done1, done3;
  logic [4:0]  idx1, idx3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decoder_sweep #(.SEL_W(5), .STEP_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .i(i),
    .sweep_start(start1), .sweep_abort(abort1),
    .d(d1), .busy(busy1), .done(done1), .idx(idx1)
  );

  decoder_sweep #(.SEL_W(5), .STEP_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .i(i),
    .sweep_start(start3), .sweep_abort(abort3),
    .d(d3), .busy(busy3), .done(done3), .idx(idx3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output must never be multi-hot, on either instance.
  always @(negedge clk) begin
    chk("onehot0_d1", {31'b0, $onehot0(d1)}, 32'd1);
    chk("onehot0_d3", {31'b0, $onehot0(d3)}, 32'd1);
  end

  initial begin
    int cyc;
    logic [31:0] exp;

    // Reset state
    tick();
    chk("rst_d1", d1, 32'h0);
    chk("rst_busy1", {31'b0, busy1}, 32'h0);
    chk("rst_done1", {31'b0, done1}, 32'h0);
    chk("rst_idx1", {27'b0, idx1}, 32'h0);
    chk("rst_d3", d3, 32'h0);
    rst = 1'b0;

    // Direct decode of every select, then disable
    en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      i = 5'(k);
      tick();
      exp = (k < FIRST_TB) ? 32'h0 : (32'h1 << k);
      chk("dec_d1", d1, exp);
      chk("dec_d3", d3, exp);
    end
    en = 1'b0;
    tick();
    chk("dec_off_d1", d1, 32'h0);

    // sweep_abort outside a sweep has no effect
    en = 1'b1; i = 5'd3; abort1 = 1'b1;
    tick();
    abort1 = 1'b0; en = 1'b0;
    chk("abort_idle_d1", d1, 32'h8);
    chk("abort_idle_busy1", {31'b0, busy1}, 32'h0);
    tick();

    // Full sweep, hold 1
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = FIRST_TB; k < 32; k++) begin
      chk("sw1_d", d1, 32'h1 << k);
      chk("sw1_busy", {31'b0, busy1}, 32'h1);
      chk("sw1_idx", {27'b0, idx1}, 32'(k));
      chk("sw1_done", {31'b0, done1}, 32'h0);
      tick();
    end
    chk("sw1_end_done", {31'b0, done1}, 32'h1);
    chk("sw1_end_d", d1, 32'h0);
    chk("sw1_end_busy", {31'b0, busy1}, 32'h0);
    chk("sw1_end_idx", {27'b0, idx1}, 32'h0);
    tick();
    chk("sw1_idle_done", {31'b0, done1}, 32'h0);
    chk("sw1_idle_busy", {31'b0, busy1}, 32'h0);

    // Full sweep, hold 3 (busy cycles bounded)
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cyc = 0;
    while (busy3 && cyc < 200) begin
      chk("sw3_d", d3, 32'h1 << (FIRST_TB + cyc / 3));
      chk("sw3_done", {31'b0, done3}, 32'h0);
      cyc++;
      tick();
    end
    chk("sw3_busy_cycles", 32'(cyc), 32'(3 * (32 - FIRST_TB)));
    chk("sw3_end_done", {31'b0, done3}, 32'h1);
    chk("sw3_end_d", d3, 32'h0);
    tick();
    chk("sw3_single_done", {31'b0, done3}, 32'h0);

    // sweep_start beats en; en/i ignored during sweep
    en = 1'b1; i = 5'h04; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("prio_d1", d1, 32'h1 << FIRST_TB);
    i = 5'd9;
    tick();
    chk("ign1_d1", d1, 32'h1 << (FIRST_TB + 1));
    en = 1'b0; i = 5'd20;
    tick();
    chk("ign2_d1", d1, 32'h1 << (FIRST_TB + 2));

    // Abort at idx 7
    cyc = 0;
    while (idx1 != 5'd7 && cyc < 64) begin
      cyc++;
      tick();
    end
    chk("reach_idx7", {27'b0, idx1}, 32'd7);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("abort_d1", d1, 32'h0);
    chk("abort_busy1", {31'b0, busy1}, 32'h0);
    chk("abort_done1", {31'b0, done1}, 32'h0);
    chk("abort_idx1", {27'b0, idx1}, 32'h0);
    tick();
    chk("abort_nodone1", {31'b0, done1}, 32'h0);

    // Reset at idx 12 in a second run
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 0;
    while (idx1 != 5'd12 && cyc < 64) begin
      cyc++;
      tick();
    end
    chk("reach_idx12", {27'b0, idx1}, 32'd12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_d1", d1, 32'h0);
    chk("mrst_busy1", {31'b0, busy1}, 32'h0);
    chk("mrst_done1", {31'b0, done1}, 32'h0);
    chk("mrst_idx1", {27'b0, idx1}, 32'h0);
    tick();
    chk("mrst_nodone1", {31'b0, done1}, 32'h0);
    chk("mrst_idle_busy1", {31'b0, busy1}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
